instr_encode_loader: RTL

//  Inverse of the instruction-decode controller: takes symbolic instructions
//  (mnemonic ID + fields) over a valid/ready stream and encodes them into
//  32-bit MIPS words. Writes them sequentially into instruction memory from a

---
 rtl/instr_encode_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_encode_loader.sv
// Encodes symbolic instructions into 32-bit MIPS words and writes them to instruction memory.
// Optional feature: define LOADER_CHECKSUM_EN for a running XOR checksum of written words.
module instr_encode_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] addr_ptr;
  logic              accept;
  logic              load_start;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic              err_q;

  function automatic logic [31:0] encode(
    input logic [4:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (mnem)
      5'd0:  w = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
      5'd1:  w = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
      5'd2:  w = {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
      5'd3:  w = {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
      5'd4:  w = {6'b000000, rs, rt, rd, 5'b0, 6'b100111};
      5'd5:  w = {6'b000000, rs, rt, rd, 5'b0, 6'b100110};
      5'd6:  w = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
      5'd7:  w = {6'b000000, 5'b0, rt, rd, shamt, 6'b000000};
      5'd8:  w = {6'b000000, 5'b0, rt, rd, shamt, 6'b000010};
      5'd9:  w = {6'b000000, rs, 15'b0, 6'b001000};
      5'd10: w = {6'b011100, rs, rt, rd, 5'b0, 6'b000010};
      5'd11: w = {6'b001000, rs, rt, imm};
      5'd12: w = {6'b001100, rs, rt, imm};
      5'd13: w = {6'b001101, rs, rt, imm};
      5'd14: w = {6'b001110, rs, rt, imm};
      5'd15: w = {6'b001010, rs, rt, imm};
      5'd16: w = {6'b100000, rs, rt, imm};
      5'd17: w = {6'b100001, rs, rt, imm};
      5'd18: w = {6'b100011, rs, rt, imm};
      5'd19: w = {6'b101000, rs, rt, imm};
      5'd20: w = {6'b101001, rs, rt, imm};
      5'd21: w = {6'b101011, rs, rt, imm};
      5'd22: w = {6'b000100, rs, rt, imm};
      5'd23: w = {6'b000101, rs, rt, imm};
      // REGIMM branches carry their sub-opcode in the rt slot
      5'd24: w = {6'b000001, rs, 5'b00001, imm};
      5'd25: w = {6'b000001, rs, 5'b00000, imm};
      5'd26: w = {6'b000111, rs, 5'b00000, imm};
      5'd27: w = {6'b000110, rs, 5'b00000, imm};
      5'd28: w = {6'b000010, target};
      5'd29: w = {6'b000011, target};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign in_ready   = (state == RUN);
  assign accept     = in_valid && (state == RUN);
  assign load_start = start && (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : RUN;
      RUN:     if (in_valid && remaining == CNT_W'(1)) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: accepted beat becomes a registered memory write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      remaining <= '0;
      addr_ptr  <= '0;
      err_q     <= 1'b0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= accept;
      if (load_start) begin
        remaining <= count;
        addr_ptr  <= base_addr;
        err_q     <= 1'b0;
      end
      if (accept) begin
        remaining <= remaining - CNT_W'(1);
        addr_ptr  <= addr_ptr + ADDR_W'(1);
        addr_p1   <= addr_ptr;
        wdata_p1  <= encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
        if (in_mnem >= 5'd30) err_q <= 1'b1;
      end
    end
  end

  assign mem_we      = vld_p1;
  assign mem_addr    = addr_p1;
  assign mem_wdata   = wdata_p1;
  assign err_illegal = err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_p2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      csum_p2 <= '0;
    end else if (load_start) begin
      csum_p2 <= '0;
    end else if (vld_p1) begin
      csum_p2 <= csum_p2 ^ wdata_p1;
    end
  end

  assign checksum = csum_p2;
`else
  assign checksum = '0;
`endif

endmodule
